// File: rtl/custom_types_pkg.sv
// Shared types for the multi-core memory bus: core index, arbiter states and
// the round-robin pointer helper.
package custom_types_pkg;

    localparam int CACHE_W = 2;

    // Index of a core; with two cores a single bit names either one.
    typedef logic coherence_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_DGNT = 2'b01,
        ARB_IGNT = 2'b10
    } arb_state_t;

    // Pointer moves past the core just granted, wrapping modulo CACHE_W.
    function automatic coherence_t rr_next(coherence_t k);
        return k + 1'b1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick between the two cores: the core named by ptr
// wins if it is requesting, otherwise the other requesting core wins.
module rr_select
    import custom_types_pkg::*;
#(
    parameter int N = CACHE_W
) (
    input  logic [N-1:0] req,
    input  coherence_t   ptr,
    output logic [N-1:0] gnt,
    output coherence_t   idx,
    output logic         vld
);

    coherence_t other;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        vld   = 1'b0;
        other = ~ptr;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
            idx      = ptr;
            vld      = 1'b1;
        end else if (req[other]) begin
            gnt[other] = 1'b1;
            idx        = other;
            vld        = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Memory bus arbiter for two cores: dcache requests beat icache requests,
// round-robin among cores, grant held until the memory controller reports done.
module bus_arbiter
    import custom_types_pkg::*;
#(
    parameter int CACHE_W = custom_types_pkg::CACHE_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CACHE_W-1:0] dreq,
    input  logic [CACHE_W-1:0] ireq,
    input  logic               txn_done,
    output logic [CACHE_W-1:0] dgnt,
    output logic [CACHE_W-1:0] igrnt,
    output coherence_t         arb,
    output logic               bus_busy
);

    arb_state_t         state_q, state_d;
    coherence_t         dptr_q, dptr_d;
    coherence_t         iptr_q, iptr_d;
    logic [CACHE_W-1:0] dgnt_q, dgnt_d;
    logic [CACHE_W-1:0] igrnt_q, igrnt_d;
    coherence_t         arb_q, arb_d;

    logic [CACHE_W-1:0] d_win, i_win;
    coherence_t         d_idx, i_idx;
    logic               d_vld, i_vld;

    rr_select #(.N(CACHE_W)) u_dsel (
        .req (dreq),
        .ptr (dptr_q),
        .gnt (d_win),
        .idx (d_idx),
        .vld (d_vld)
    );

    rr_select #(.N(CACHE_W)) u_isel (
        .req (ireq),
        .ptr (iptr_q),
        .gnt (i_win),
        .idx (i_idx),
        .vld (i_vld)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ARB_IDLE;
            dptr_q  <= '0;
            iptr_q  <= '0;
            dgnt_q  <= '0;
            igrnt_q <= '0;
            arb_q   <= '0;
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
            dgnt_q  <= dgnt_d;
            igrnt_q <= igrnt_d;
            arb_q   <= arb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
        dgnt_d  = dgnt_q;
        igrnt_d = igrnt_q;
        arb_d   = arb_q;
        case (state_q)
            ARB_IDLE: begin
                // Grants only start from idle, which forces a gap cycle after
                // every done so a stale request cannot be re-granted.
                if (d_vld) begin
                    state_d = ARB_DGNT;
                    dgnt_d  = d_win;
                    arb_d   = d_idx;
                    dptr_d  = rr_next(d_idx);
                end else if (i_vld) begin
                    state_d = ARB_IGNT;
                    igrnt_d = i_win;
                    arb_d   = i_idx;
                    iptr_d  = rr_next(i_idx);
                end
            end
            ARB_DGNT, ARB_IGNT: begin
                if (txn_done) begin
                    state_d = ARB_IDLE;
                    dgnt_d  = '0;
                    igrnt_d = '0;
                    arb_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                dgnt_d  = '0;
                igrnt_d = '0;
                arb_d   = '0;
            end
        endcase
    end

    assign dgnt     = dgnt_q;
    assign igrnt    = igrnt_q;
    assign arb      = arb_q;
    assign bus_busy = |(dgnt_q | igrnt_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of who owns the bus.
module tb_bus_arbiter;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] dreq;
    logic [1:0] ireq;
    logic       txn_done;
    logic [1:0] dgnt;
    logic [1:0] igrnt;
    logic       arb;
    logic       bus_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus (none / d or i of a core) and the preferred cores.
    int m_busy = 0;
    int m_isd  = 0;
    int m_core = 0;
    int m_dptr = 0;
    int m_iptr = 0;

    always #5 CLK = ~CLK;

    bus_arbiter #(.CACHE_W(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dreq     (dreq),
        .ireq     (ireq),
        .txn_done (txn_done),
        .dgnt     (dgnt),
        .igrnt    (igrnt),
        .arb      (arb),
        .bus_busy (bus_busy)
    );

    function automatic int pick(logic [1:0] req, int ptr);
        return req[ptr] ? ptr : 1 - ptr;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_isd  = 0;
        m_core = 0;
        m_dptr = 0;
        m_iptr = 0;
    endtask

    task automatic model_edge();
        if (!nRST) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (dreq != 2'b00) begin
                m_core = pick(dreq, m_dptr);
                m_isd  = 1;
                m_busy = 1;
                m_dptr = (m_core + 1) % 2;
            end else if (ireq != 2'b00) begin
                m_core = pick(ireq, m_iptr);
                m_isd  = 0;
                m_busy = 1;
                m_iptr = (m_core + 1) % 2;
            end
        end else if (txn_done) begin
            m_busy = 0;
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [1:0] e_d, e_i;
        logic       e_a;
        e_d = 2'b00;
        e_i = 2'b00;
        e_a = 1'b0;
        if (m_busy != 0) begin
            if (m_isd != 0) e_d[m_core] = 1'b1;
            else            e_i[m_core] = 1'b1;
            e_a = (m_core != 0);
        end
        chk({tag, ".dgnt"},  {6'd0, dgnt},  {6'd0, e_d});
        chk({tag, ".igrnt"}, {6'd0, igrnt}, {6'd0, e_i});
        chk({tag, ".arb"},   {7'd0, arb},   {7'd0, e_a});
        chk({tag, ".busy"},  {7'd0, bus_busy}, {7'd0, m_busy != 0});
        chk({tag, ".onehot"}, 8'($countones({dgnt, igrnt}) <= 1), 8'd1);
    endtask

    task automatic step(string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        nRST     = 1'b0;
        dreq     = 2'b11;
        ireq     = 2'b00;
        txn_done = 1'b0;

        // Reset held with requests present
        #2;
        model_reset();
        check_all("rst_hold");
        step("rst_edge0");
        step("rst_edge1");
        chk("rst_dgnt", {6'd0, dgnt}, 8'h00);
        nRST = 1'b1;

        // Both cores request d: core 0 first, idle gap, then core 1
        step("d11_g0");
        chk("d11_first", {6'd0, dgnt}, 8'h01);
        txn_done = 1'b1;
        step("d11_done");
        txn_done = 1'b0;
        step("d11_g1");
        chk("d11_second", {6'd0, dgnt}, 8'h02);
        chk("d11_arb", {7'd0, arb}, 8'h01);
        txn_done = 1'b1;
        dreq = 2'b00;
        step("d11_end");
        txn_done = 1'b0;

        // d beats i, then i granted after the gap
        dreq = 2'b01;
        ireq = 2'b10;
        step("di_d");
        chk("di_dfirst", {6'd0, dgnt}, 8'h01);
        txn_done = 1'b1;
        dreq = 2'b00;
        step("di_done");
        txn_done = 1'b0;
        step("di_i");
        chk("di_igrnt", {6'd0, igrnt}, 8'h02);
        txn_done = 1'b1;
        ireq = 2'b00;
        step("di_end");
        txn_done = 1'b0;

        // Held request, done every third granted cycle
        dreq = 2'b01;
        for (int g = 0; g < 4; g++) begin
            step("hold_g1");
            step("hold_g2");
            txn_done = 1'b1;
            step("hold_g3");
            txn_done = 1'b0;
            chk("hold_gap", {6'd0, dgnt}, 8'h00);
        end

        // Async reset in the middle of a core-1 grant
        dreq = 2'b11;
        step("ar_g");
        chk("ar_g10", {6'd0, dgnt}, 8'h02);
        #3;
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("ar_async");
        step("ar_hold");
        nRST = 1'b1;
        step("ar_rel");
        chk("ar_rel01", {6'd0, dgnt}, 8'h01);

        // Done ignored in idle; dropped request keeps grant
        dreq = 2'b00;
        txn_done = 1'b1;
        step("idle_done0");
        step("idle_done1");
        chk("idle_quiet", {7'd0, bus_busy}, 8'h00);
        txn_done = 1'b0;
        dreq = 2'b01;
        step("drop_g");
        dreq = 2'b00;
        step("drop_h1");
        step("drop_h2");
        chk("drop_keep", {6'd0, dgnt}, 8'h01);
        txn_done = 1'b1;
        step("drop_done");
        txn_done = 1'b0;

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 400; c++) begin
            dreq     = 2'($urandom_range(0, 3));
            ireq     = 2'($urandom_range(0, 3));
            txn_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) dreq = 2'b00;
            step("rand");
            if ($urandom_range(0, 99) == 0) begin
                #2;
                nRST = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                #1;
                nRST = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter CACHE_W, default 2, number of cores/cache pairs sharing the memory bus; only 2 is supported.
REQ-002 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dreq  in  CACHE_W  per-core dcache bus request (dREN|dWEN).
REQ-005 SHALL have port ireq  in  CACHE_W  per-core icache bus request (iREN).
REQ-006 SHALL have port txn_done  in  1  single-cycle pulse from memory control: granted transaction complete.
REQ-007 SHALL have port dgnt  out  CACHE_W  one-hot dcache grant.
REQ-008 SHALL have port igrnt  out  CACHE_W  one-hot icache grant.
REQ-009 SHALL have port arb  out  coherence_t  index of granted core; snooped core is the other one.
REQ-010 SHALL have port bus_busy  out  1  high while any grant is held.

Function
REQ-011 SHALL implement states ARB_IDLE, ARB_DGNT, ARB_IGNT.
REQ-012 ARB_IDLE: any dreq -> ARB_DGNT; else any ireq -> ARB_IGNT; else stay.
REQ-013 dcache requests SHALL have absolute priority over icache requests.
REQ-014 Among cores, selection SHALL be round-robin: separate pointers dptr, iptr name the preferred core; if the preferred core is not requesting, the other requesting core wins.
REQ-015 On granting core k, the matching pointer SHALL become (k+1) mod CACHE_W; the other pointer is unchanged.
REQ-016 Grant latency: request sampled at edge N, grant registered and visible after edge N+1 (one cycle).
REQ-017 dgnt/igrnt/arb SHALL be registered, stay constant for the whole grant, and be zero in ARB_IDLE.
REQ-018 ARB_DGNT/ARB_IGNT -> ARB_IDLE on the edge where txn_done=1; no other exit.
REQ-019 Minimum one ARB_IDLE cycle between grants, so a requester's stale request in the done cycle is never re-granted.
REQ-020 txn_done in ARB_IDLE SHALL be ignored.
REQ-021 A requester dropping its request while granted SHALL NOT remove the grant; the grant holds until txn_done.
REQ-022 At most one bit across dgnt|igrnt SHALL be set in any cycle.
REQ-023 bus_busy SHALL equal |(dgnt|igrnt).

Reset
REQ-024 nRST low SHALL immediately force state ARB_IDLE, dgnt=0, igrnt=0, arb=0, bus_busy=0, dptr=0, iptr=0, including mid-grant.
REQ-025 First arbitration after nRST release SHALL favour core 0 for both d and i.

Structure
REQ-026 arb_state_t enum (ARB_IDLE, ARB_DGNT, ARB_IGNT) SHALL be added to custom_types_pkg; coherence_t and CACHE_W SHALL be reused from it.
REQ-027 Round-robin selection SHALL be one combinational sub-module rr_select (inputs req vector, pointer; outputs one-hot winner, index, valid), instantiated twice (d, i).

Verification
REQ-028 Reset: hold nRST=0 with dreq=2'b11 -> dgnt=0, igrnt=0, arb=0, bus_busy=0.
REQ-029 From reset, dreq=2'b11 -> next cycle dgnt=01, arb=0; pulse txn_done -> one idle cycle (dgnt=00) -> dgnt=10, arb=1.
REQ-030 dreq=01 and ireq=10 together -> dgnt=01 first; after txn_done and idle cycle, igrnt=10, arb=1.
REQ-031 dreq=01 held continuously, txn_done every 3rd granted cycle -> grant 01 repeats with exactly one idle cycle between grants; no spurious 10.
REQ-032 nRST pulsed low during dgnt=10 -> all outputs 0 asynchronously; after release with dreq=11, dgnt=01.
REQ-033 txn_done pulsed in ARB_IDLE with no requests -> outputs stay 0; dreq dropped to 00 during dgnt=01 -> dgnt stays 01 until txn_done.
